matmul_engine: RTL

Parametrised, runtime-configurable fixed-point matrix multiplier computing Z = X·Y for signed Q-format operands held in external single-port-read RAMs. Each output element goes through a multiply-accumulate pass over the inner dimension, then a rounding and saturation stage. Matrix dimensions and base addresses are programmed per job, and the RAM read latency is a parameter. It sits between the DFR reservoir state memory and the output-layer weight memory, and replaces fixed-size, integer-only multiplication.

---
 rtl/matmul_pkg.sv | 49 ++++
 rtl/matmul_mac.sv | 55 +++++
 rtl/matmul_engine.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the fixed-point matrix multiplier.
package matmul_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMac,
        StDrain,
        StWrite,
        StDone
    } state_t;

    localparam int unsigned MinRamLatency = 1;
    localparam int unsigned MaxAccWidth   = 128;
    localparam int unsigned MaxDataWidth  = 64;

    typedef struct packed {
        logic                    sat;
        logic [MaxDataWidth-1:0] value;
    } round_sat_t;

    // Round half up by frac_bits, then clamp to a signed data_width result.
    function automatic round_sat_t round_sat(input logic signed [MaxAccWidth-1:0] acc,
                                             input int unsigned data_width,
                                             input int unsigned frac_bits);
        logic signed [MaxAccWidth-1:0] one;
        logic signed [MaxAccWidth-1:0] rounded;
        logic signed [MaxAccWidth-1:0] max_val;
        logic signed [MaxAccWidth-1:0] min_val;
        round_sat_t res;
        one     = {{(MaxAccWidth-1){1'b0}}, 1'b1};
        rounded = acc;
        if (frac_bits > 0) begin
            rounded = (acc + (one <<< (frac_bits - 1))) >>> frac_bits;
        end
        max_val   = (one <<< (data_width - 1)) - one;
        min_val   = ~max_val;
        res.sat   = 1'b0;
        res.value = rounded[MaxDataWidth-1:0];
        if (rounded > max_val) begin
            res.sat   = 1'b1;
            res.value = max_val[MaxDataWidth-1:0];
        end else if (rounded < min_val) begin
            res.sat   = 1'b1;
            res.value = min_val[MaxDataWidth-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Read-valid tracking, multiply-accumulate and round/saturate of one output element.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned FRAC_BITS   = 16,
    parameter int unsigned ACC_WIDTH   = 80,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ren,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] x_rdata,
    input  logic [DATA_WIDTH-1:0] y_rdata,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  sat
);

    logic [RAM_LATENCY-1:0]         vld_q;
    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic signed [2*DATA_WIDTH-1:0] product;
    round_sat_t                     rs;
    logic                           unused_rs;

    assign product = $signed(x_rdata) * $signed(y_rdata);

    if (RAM_LATENCY == 1) begin : g_vld_single
        always_ff @(posedge clk or posedge rst) begin
            if (rst) vld_q <= '0;
            else     vld_q <= ren;
        end
    end else begin : g_vld_shift
        always_ff @(posedge clk or posedge rst) begin
            if (rst) vld_q <= '0;
            else     vld_q <= {vld_q[RAM_LATENCY-2:0], ren};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (vld_q[RAM_LATENCY-1]) begin
            acc_q <= acc_q + ACC_WIDTH'(product);
        end
    end

    assign rs        = round_sat(MaxAccWidth'(acc_q), DATA_WIDTH, FRAC_BITS);
    assign result    = rs.value[DATA_WIDTH-1:0];
    assign sat       = rs.sat;
    assign unused_rs = ^rs.value[MaxDataWidth-1:DATA_WIDTH];

endmodule

// File: rtl/matmul_engine.sv
// Runtime-configurable Q-format matrix multiplier Z = X*Y over external read RAMs.
module matmul_engine
    import matmul_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned FRAC_BITS   = 16,
    parameter int unsigned DIM_WIDTH   = 16,
    parameter int unsigned RAM_LATENCY = 1,
    parameter int unsigned ACC_WIDTH   = 2 * DATA_WIDTH + DIM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  cfg_m,
    input  logic [DIM_WIDTH-1:0]  cfg_k,
    input  logic [DIM_WIDTH-1:0]  cfg_n,
    input  logic [ADDR_WIDTH-1:0] x_base,
    input  logic [ADDR_WIDTH-1:0] y_base,
    input  logic [ADDR_WIDTH-1:0] z_base,
    output logic [ADDR_WIDTH-1:0] x_addr,
    output logic [ADDR_WIDTH-1:0] y_addr,
    output logic                  x_ren,
    output logic                  y_ren,
    input  logic [DATA_WIDTH-1:0] x_rdata,
    input  logic [DATA_WIDTH-1:0] y_rdata,
    output logic [ADDR_WIDTH-1:0] z_addr,
    output logic [DATA_WIDTH-1:0] z_data,
    output logic                  z_wen,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  sat_flag
);

    localparam bit          LatencyOk   = (RAM_LATENCY >= MinRamLatency);
    localparam int unsigned LatCntWidth = $clog2(RAM_LATENCY + 1);

    if (!LatencyOk) begin : g_latency_check
        $error("RAM_LATENCY must be at least %0d", MinRamLatency);
    end

    state_t                 state_q;
    logic [DIM_WIDTH-1:0]   cfg_m_q, cfg_k_q, cfg_n_q;
    logic [DIM_WIDTH-1:0]   i_q, j_q, k_q;
    logic [ADDR_WIDTH-1:0]  y_base_q;
    logic [ADDR_WIDTH-1:0]  x_row_q, y_col_q, z_ptr_q;
    logic [ADDR_WIDTH-1:0]  x_addr_q, y_addr_q, z_addr_q;
    logic [LatCntWidth-1:0] lat_cnt_q;
    logic                   ren_q, z_wen_q, busy_q, done_q, err_q, sat_flag_q;
    logic                   mac_clear, mac_sat;
    logic [DATA_WIDTH-1:0]  mac_result;
    logic [ADDR_WIDTH-1:0]  x_next_row;

    assign x_next_row = x_row_q + ADDR_WIDTH'(cfg_k_q);
    assign mac_clear  = (state_q == StIdle) || (state_q == StWrite);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cfg_m_q    <= '0;
            cfg_k_q    <= '0;
            cfg_n_q    <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            y_base_q   <= '0;
            x_row_q    <= '0;
            y_col_q    <= '0;
            z_ptr_q    <= '0;
            x_addr_q   <= '0;
            y_addr_q   <= '0;
            z_addr_q   <= '0;
            lat_cnt_q  <= '0;
            ren_q      <= 1'b0;
            z_wen_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            sat_flag_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (cfg_m == '0 || cfg_k == '0 || cfg_n == '0) begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            cfg_m_q    <= cfg_m;
                            cfg_k_q    <= cfg_k;
                            cfg_n_q    <= cfg_n;
                            y_base_q   <= y_base;
                            i_q        <= '0;
                            j_q        <= '0;
                            k_q        <= '0;
                            x_row_q    <= x_base;
                            y_col_q    <= y_base;
                            z_ptr_q    <= z_base;
                            x_addr_q   <= x_base;
                            y_addr_q   <= y_base;
                            ren_q      <= 1'b1;
                            busy_q     <= 1'b1;
                            sat_flag_q <= 1'b0;
                            state_q    <= StMac;
                        end
                    end
                end
                StMac: begin
                    if (k_q == cfg_k_q - DIM_WIDTH'(1)) begin
                        ren_q     <= 1'b0;
                        lat_cnt_q <= '0;
                        state_q   <= StDrain;
                    end else begin
                        k_q      <= k_q + DIM_WIDTH'(1);
                        x_addr_q <= x_addr_q + ADDR_WIDTH'(1);
                        y_addr_q <= y_addr_q + ADDR_WIDTH'(cfg_n_q);
                    end
                end
                StDrain: begin
                    if (lat_cnt_q == LatCntWidth'(RAM_LATENCY - 1)) begin
                        z_wen_q  <= 1'b1;
                        z_addr_q <= z_ptr_q;
                        state_q  <= StWrite;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + LatCntWidth'(1);
                    end
                end
                StWrite: begin
                    z_wen_q <= 1'b0;
                    z_ptr_q <= z_ptr_q + ADDR_WIDTH'(1);
                    k_q     <= '0;
                    if (mac_sat) sat_flag_q <= 1'b1;
                    if (j_q != cfg_n_q - DIM_WIDTH'(1)) begin
                        j_q      <= j_q + DIM_WIDTH'(1);
                        y_col_q  <= y_col_q + ADDR_WIDTH'(1);
                        x_addr_q <= x_row_q;
                        y_addr_q <= y_col_q + ADDR_WIDTH'(1);
                        ren_q    <= 1'b1;
                        state_q  <= StMac;
                    end else if (i_q != cfg_m_q - DIM_WIDTH'(1)) begin
                        j_q      <= '0;
                        i_q      <= i_q + DIM_WIDTH'(1);
                        x_row_q  <= x_next_row;
                        y_col_q  <= y_base_q;
                        x_addr_q <= x_next_row;
                        y_addr_q <= y_base_q;
                        ren_q    <= 1'b1;
                        state_q  <= StMac;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    matmul_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_WIDTH  (ACC_WIDTH),
        .RAM_LATENCY(RAM_LATENCY)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .ren    (ren_q),
        .clear  (mac_clear),
        .x_rdata(x_rdata),
        .y_rdata(y_rdata),
        .result (mac_result),
        .sat    (mac_sat)
    );

    assign x_addr   = x_addr_q;
    assign y_addr   = y_addr_q;
    assign x_ren    = ren_q;
    assign y_ren    = ren_q;
    assign z_addr   = z_addr_q;
    assign z_wen    = z_wen_q;
    assign z_data   = z_wen_q ? mac_result : '0;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign sat_flag = sat_flag_q;

endmodule
